// File: rtl/oam_dma.sv
// Sprite-DMA engine: a CPU write to DMA_REG_ADDR stalls the CPU and copies page {page,00..FF} into OAM.
// Optional odd-cycle alignment penalty enabled by defining OAM_DMA_PARITY_ALIGN_EN.
`timescale 1ns/1ps
module oam_dma #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    REG_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = 'h4014
) (
    input  logic                  phi0,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [REG_WIDTH-1:0]  cpu_data,
    input  logic                  cpu_R_W_n,
    output logic                  rdy,
    output logic                  dma_active,
    output logic [ADDR_WIDTH-1:0] dma_addr,
    output logic                  dma_rd,
    input  logic [REG_WIDTH-1:0]  dma_rdata,
    output logic [7:0]            oam_addr,
    output logic [REG_WIDTH-1:0]  oam_wdata,
    output logic                  oam_we
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [REG_WIDTH-1:0]    r_page;
    logic [7:0]              r_index;
    logic [ADDR_WIDTH-1:0]   r_dma_addr;
    logic [7:0]              r_oam_addr;
    logic [REG_WIDTH-1:0]    r_byte;
    logic [7:0]              w_rd_index;
    logic                    w_trigger;
    logic                    w_align;

    assign w_trigger = (r_state == S_IDLE) && !cpu_R_W_n && (cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_PARITY_ALIGN_EN
    logic r_parity;

    always_ff @(posedge phi0 or posedge reset) begin
        if (reset) r_parity <= 1'b0;
        else       r_parity <= ~r_parity;
    end

    assign w_align = r_parity;
`else
    assign w_align = 1'b0;
`endif

    always_ff @(posedge phi0 or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger) w_next = S_HALT;
            S_HALT:  w_next = w_align ? S_ALIGN : S_READ;
            S_ALIGN: w_next = S_READ;
            S_READ:  w_next = S_WRITE;
            S_WRITE: w_next = (r_index == 8'hFF) ? S_IDLE : S_READ;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rdy        = (r_state == S_IDLE);
        dma_active = (r_state != S_IDLE);
        dma_rd     = (r_state == S_READ);
        oam_we     = (r_state == S_WRITE);
    end

    // The read address is loaded on entry to READ, so a WRITE->READ hop must see the incremented index.
    assign w_rd_index = (r_state == S_WRITE) ? (r_index + 8'd1) : r_index;

    always_ff @(posedge phi0 or posedge reset) begin
        if (reset) begin
            r_page     <= '0;
            r_index    <= '0;
            r_dma_addr <= '0;
            r_oam_addr <= '0;
            r_byte     <= '0;
        end else begin
            if (w_trigger) begin
                r_page  <= cpu_data;
                r_index <= '0;
            end
            if (w_next == S_READ)
                r_dma_addr <= ADDR_WIDTH'({r_page, w_rd_index});
            if (r_state == S_READ) begin
                r_oam_addr <= r_index;
                r_byte     <= dma_rdata;
            end
            if (r_state == S_WRITE)
                r_index <= r_index + 8'd1;
        end
    end

    assign dma_addr  = r_dma_addr;
    assign oam_addr  = r_oam_addr;
    assign oam_wdata = r_byte;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: bus-decode vectors, a table of page transfers and reset/retrigger corners.
`timescale 1ns/1ps
module tb_oam_dma;

`ifdef OAM_DMA_PARITY_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        phi0 = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data = 8'h00;
    logic        cpu_R_W_n = 1'b1;
    logic        rdy, dma_active, dma_rd, oam_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_rdata, oam_addr, oam_wdata;

    logic [7:0]  mem [0:65535];
    int          edges;
    int          errors = 0;
    int          checks = 0;

    oam_dma dut (
        .phi0(phi0), .reset(reset), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_R_W_n(cpu_R_W_n), .rdy(rdy), .dma_active(dma_active), .dma_addr(dma_addr),
        .dma_rd(dma_rd), .dma_rdata(dma_rdata), .oam_addr(oam_addr),
        .oam_wdata(oam_wdata), .oam_we(oam_we)
    );

    always #5 phi0 = ~phi0;

    assign dma_rdata = mem[dma_addr];

    // Edges since reset release; the parity seen in HALT is this count taken just after the trigger edge.
    always @(posedge phi0 or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        cpu_R_W_n = 1'b1;
        cpu_addr  = 16'($urandom);
        cpu_data  = 8'($urandom);
    endtask

    task automatic bus_noise();
        cpu_R_W_n = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom);
        cpu_data  = 8'($urandom);
        if (cpu_addr == 16'h4014) cpu_addr = 16'h4015;
    endtask

    function automatic int stall_for(input int par);
        return 513 + ((ALIGN_EN && par == 1) ? 1 : 0);
    endfunction

    // Drives the trigger so that the HALT cycle sees the wanted parity; returns at the HALT negedge.
    task automatic do_trigger(input logic [7:0] page, input int want_par, output int par);
        @(negedge phi0);
        if (((edges + 1) & 1) != want_par) @(negedge phi0);
        par       = (edges + 1) & 1;
        cpu_addr  = 16'h4014;
        cpu_R_W_n = 1'b0;
        cpu_data  = page;
        @(negedge phi0);
        idle_bus();
    endtask

    task automatic observe(input logic [7:0] page, input int exp_stall, input bit rewrite, input bit hold_tail);
        int         cyc, nrd, nwr, bad_rd, bad_wr, bad_ctl, first_rd, bad, exp_first;
        logic [7:0] cap  [0:255];
        bit         seen [0:255];
        exp_first = exp_stall - 512;
        cyc = 0; nrd = 0; nwr = 0; bad_rd = 0; bad_wr = 0; bad_ctl = 0; first_rd = -1;
        for (int i = 0; i < 256; i++) begin
            seen[i] = 1'b0;
            cap[i]  = 8'h00;
        end
        while (rdy === 1'b0 && cyc < 1000) begin
            if (dma_active !== 1'b1 || (dma_rd === 1'b1 && oam_we === 1'b1)) bad_ctl++;
            if (dma_rd === 1'b1) begin
                if (first_rd < 0) first_rd = cyc;
                if (nrd >= 256 || dma_addr !== {page, nrd[7:0]} || cyc != exp_first + 2 * nrd) bad_rd++;
                nrd++;
            end
            if (oam_we === 1'b1) begin
                if (nwr >= 256 || oam_addr !== nwr[7:0] || cyc != exp_first + 1 + 2 * nwr) bad_wr++;
                else begin
                    cap[oam_addr]  = oam_wdata;
                    seen[oam_addr] = 1'b1;
                end
                nwr++;
            end
            if (rewrite && cyc == 40) begin
                cpu_addr = 16'h4014; cpu_R_W_n = 1'b0; cpu_data = 8'h05;
            end else if (hold_tail && cyc >= exp_stall - 3) begin
                cpu_addr = 16'h4014; cpu_R_W_n = 1'b0; cpu_data = page ^ 8'h5A;
            end else begin
                bus_noise();
            end
            cyc++;
            @(negedge phi0);
        end
        if (!hold_tail) idle_bus();
        check("stall_cycles", cyc, exp_stall);
        check("first_read_cycle", first_rd, exp_first);
        check("read_count", nrd, 256);
        check("write_count", nwr, 256);
        check("read_sequence_errs", bad_rd, 0);
        check("write_sequence_errs", bad_wr, 0);
        check("active_strobe_errs", bad_ctl, 0);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (!seen[i] || cap[i] !== mem[{page, i[7:0]}]) bad++;
        check("oam_content_errs", bad, 0);
        check("dma_addr_hold", dma_addr, {page, 8'hFF});
        check("oam_addr_hold", oam_addr, 8'hFF);
        check("idle_outputs", {dma_rd, oam_we, dma_active, rdy}, 4'b0001);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        rw_n;
        logic        exp_rdy;
    } bus_vec_t;

    typedef struct {
        logic [7:0] page;
        int         par;
        bit         rewrite;
        bit         hold;
        int         exp_stall;
    } xfer_vec_t;

    bus_vec_t  bv [5];
    xfer_vec_t xv [9];
    int        par, par2, found;

    initial begin
        bv[0] = '{16'h4014, 1'b1, 1'b1};
        bv[1] = '{16'h4015, 1'b0, 1'b1};
        bv[2] = '{16'h4013, 1'b0, 1'b1};
        bv[3] = '{16'h0014, 1'b0, 1'b1};
        bv[4] = '{16'hC014, 1'b0, 1'b1};
        xv[0] = '{8'h02, 0, 1'b0, 1'b0, stall_for(0)};
        xv[1] = '{8'h02, 1, 1'b0, 1'b0, stall_for(1)};
        xv[2] = '{8'hFF, 1, 1'b0, 1'b0, stall_for(1)};
        xv[3] = '{8'hFF, 0, 1'b0, 1'b0, stall_for(0)};
        xv[4] = '{8'h00, 1, 1'b0, 1'b0, stall_for(1)};
        xv[5] = '{8'h5A, 0, 1'b1, 1'b0, stall_for(0)};
        for (int i = 6; i < 8; i++) begin
            par = int'($urandom_range(0, 1));
            xv[i] = '{8'($urandom), par, 1'b0, 1'b0, stall_for(par)};
        end
        xv[8] = '{8'h81, 0, 1'b0, 1'b1, stall_for(0)};

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        // Reset state, with a DMA write held on the bus across reset edges.
        #2;
        check("reset_outputs", {rdy, dma_active, dma_rd, oam_we}, 4'b1000);
        check("reset_dma_addr", dma_addr, 16'h0000);
        check("reset_oam", {oam_addr, oam_wdata}, 16'h0000);
        cpu_addr = 16'h4014; cpu_R_W_n = 1'b0; cpu_data = 8'h02;
        repeat (3) @(negedge phi0);
        reset = 1'b0;
        idle_bus();
        check("reset_beats_trigger", rdy, 1'b1);

        for (int i = 0; i < 5; i++) begin
            @(negedge phi0);
            cpu_addr = bv[i].addr; cpu_R_W_n = bv[i].rw_n; cpu_data = 8'($urandom);
            @(negedge phi0);
            idle_bus();
            check($sformatf("decode_%04h_rw%0d", bv[i].addr, bv[i].rw_n), rdy, bv[i].exp_rdy);
        end

        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge phi0);
            do_trigger(xv[i].page, xv[i].par, par);
            observe(xv[i].page, xv[i].exp_stall, xv[i].rewrite, xv[i].hold);
            if (xv[i].hold) begin
                par2 = (edges + 1) & 1;
                @(negedge phi0);
                idle_bus();
                check("retrigger_after_idle", rdy, 1'b0);
                observe(xv[i].page ^ 8'h5A, stall_for(par2), 1'b0, 1'b0);
            end
        end

        // Reset in the WRITE of pair 100, then a fresh transfer from index 0.
        do_trigger(8'h07, 0, par);
        found = 0;
        for (int k = 0; k < 600 && found == 0; k++) begin
            if (oam_we === 1'b1 && oam_addr === 8'd100) found = 1;
            else @(negedge phi0);
        end
        check("pair100_reached", found, 1);
        reset = 1'b1;
        #1;
        check("midreset_ctl", {rdy, oam_we, dma_active, dma_rd}, 4'b1000);
        check("midreset_addr", {dma_addr, oam_addr}, 24'h000000);
        @(negedge phi0);
        reset = 1'b0;
        @(negedge phi0);
        check("post_reset_idle", rdy, 1'b1);
        do_trigger(8'h03, int'($urandom_range(0, 1)), par);
        observe(8'h03, stall_for(par), 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite-DMA engine that sits directly downstream of the CPU on the shared address/data bus.
- It decodes CPU writes to the OAM-DMA register (0x4014) and stalls the CPU through its rdy input.
- While the CPU is stalled it copies the 256-byte page {page, 0x00}..{page, 0xFF} into PPU OAM as alternating bus-read / OAM-write cycles.
- It releases rdy when the copy is complete.

Parameters:
- ADDR_WIDTH, 16, CPU address bus width (matches `ADDR_WIDTH).
- REG_WIDTH, 8, data bus width (matches `REG_WIDTH).
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer.

Ports:
- phi0  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_addr  in  ADDR_WIDTH  CPU address bus A.
- cpu_data  in  REG_WIDTH  CPU write data D.
- cpu_R_W_n  in  1  CPU read/write strobe; 0 = write.
- rdy  out  1  to the CPU rdy input; 0 stalls the CPU.
- dma_active  out  1  high while the engine owns the bus.
- dma_addr  out  ADDR_WIDTH  bus address driven during READ.
- dma_rd  out  1  bus read strobe.
- dma_rdata  in  REG_WIDTH  bus read data; valid and sampled at the end of the READ cycle.
- oam_addr  out  8  OAM byte index.
- oam_wdata  out  REG_WIDTH  OAM write data.
- oam_we  out  1  OAM write strobe.

Behaviour:
- Reset values (asynchronous, immediate on reset high, including mid-transfer):
  - state = IDLE, rdy = 1, dma_active = 0, dma_rd = 0, oam_we = 0.
  - dma_addr = 0, oam_addr = 0, oam_wdata = 0.
  - page register = 0, index = 0, parity flop = 0.
- Parity flop toggles every phi0 cycle after reset release.
- Trigger:
  - Condition: state == IDLE and, at a rising edge, cpu_R_W_n == 0 and cpu_addr == DMA_REG_ADDR.
  - Action: page <= cpu_data, index <= 0, state <= HALT.
- Writes to DMA_REG_ADDR in any state other than IDLE are ignored; no restart and no page change.
- rdy = (state == IDLE); dma_active = (state != IDLE). Both are decoded from registered state, so there are no glitches.
- States:
  - IDLE: wait for trigger.
  - HALT: 1 cycle, lets the CPU finish its current cycle.
    - Next state is ALIGN if parity == 1 (and the optional feature is enabled), else READ.
  - ALIGN: 1 dummy cycle, then READ.
  - READ:
    - dma_rd = 1, dma_addr = {page, index}.
    - Latch dma_rdata into the byte register at the end of the cycle, then go to WRITE.
  - WRITE:
    - oam_we = 1, oam_addr = index, oam_wdata = latched byte.
    - Then index <= index + 1 (8-bit wrap).
    - If index was 0xFF, go to IDLE; else go to READ.
- Transfer length:
  - Exactly 256 READ/WRITE pairs.
  - rdy is low for 513 cycles (HALT + 512), or 514 when ALIGN is inserted.
- Index wrap: 0xFF+1 = 0x00 terminates the transfer. The page register is never incremented, so there is no carry into the high byte.
- Outputs outside their active state:
  - dma_rd = 0 outside READ.
  - oam_we = 0 outside WRITE.
  - dma_addr and oam_addr hold their last value.
- Simultaneous trigger and reset: reset wins.
- A trigger in the same cycle the engine returns to IDLE is not accepted; it is accepted from the next cycle.

Optional Feature:
- Macro: OAM_DMA_PARITY_ALIGN_EN.
- Defined: ALIGN is inserted when the parity flop is 1 in HALT, modelling the odd-cycle penalty. Stall is 513 or 514 cycles.
- Undefined: ALIGN state is never entered (and may be omitted from the RTL). Stall is always exactly 513 cycles; the parity flop may be removed.

Test Plan:
- Reset, then write 0x02 to 0x4014 on an even parity cycle:
  - rdy low for 513 cycles.
  - dma_addr sweeps 0x0200..0x02FF.
  - OAM[i] == mem[0x0200+i] for all 256 i.
  - rdy returns high after the final WRITE.
- Same trigger on an odd parity cycle with OAM_DMA_PARITY_ALIGN_EN defined:
  - 514-cycle stall.
  - First dma_rd asserts 2 cycles after HALT entry.
- Same odd trigger with the macro undefined: 513-cycle stall.
- Page 0xFF transfer: last READ at 0xFFFF, last WRITE to oam_addr 0xFF, no read at 0x0000, state returns to IDLE.
- During an active transfer, force cpu_R_W_n = 0 at 0x4014 with data 0x05:
  - Page stays at its original value.
  - Transfer length unchanged.
- Assert reset at pair 100 (during WRITE):
  - Immediately rdy = 1, oam_we = 0, dma_active = 0.
  - A subsequent write of 0x03 to 0x4014 runs a full 256-byte transfer from index 0.
